// File: rtl/inst_mem_server.sv
// rtl/inst_mem_server.sv - fixed-latency memory responder with response buffering and backdoor load
module inst_mem_server #(
    parameter int p_addr_bits  = 32,
    parameter int p_data_bits  = 32,
    parameter int p_opaq_bits  = 8,
    parameter int p_num_words  = 256,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4,
    localparam int p_len_bits  = p_data_bits / 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [2:0]             req_op,
    input  logic [p_opaq_bits-1:0] req_opaque,
    input  logic [p_addr_bits-1:0] req_addr,
    input  logic [p_len_bits-1:0]  req_len,
    input  logic [p_data_bits-1:0] req_data,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [2:0]             resp_op,
    output logic [p_opaq_bits-1:0] resp_opaque,
    output logic [p_addr_bits-1:0] resp_addr,
    output logic [p_len_bits-1:0]  resp_len,
    output logic [p_data_bits-1:0] resp_data,
    input  logic                   init_en,
    input  logic [p_addr_bits-1:0] init_addr,
    input  logic [p_data_bits-1:0] init_data
);
    localparam int idx_bits = $clog2(p_num_words);
    localparam int msg_bits = 3 + p_opaq_bits + p_addr_bits + p_len_bits + p_data_bits;
    localparam int ptr_bits = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
    localparam int occ_bits = $clog2(p_resp_depth + 1);
    localparam logic [2:0] mem_msg_write = 3'd1;

    logic [p_data_bits-1:0] mem [p_num_words];
    logic [idx_bits-1:0]    req_idx;
    logic [idx_bits-1:0]    init_idx;
    logic                   unused_init;
    logic                   resp_xfer;
    logic                   req_xfer;
    logic                   is_write;
    logic [occ_bits-1:0]    occ;
    logic [msg_bits-1:0]    new_msg;
    logic                   push_val;
    logic [msg_bits-1:0]    push_msg;
    logic [msg_bits-1:0]    fifo [p_resp_depth];
    logic [ptr_bits-1:0]    wr_ptr;
    logic [ptr_bits-1:0]    rd_ptr;
    logic [occ_bits-1:0]    fcnt;

    // Word index wraps: upper address bits and byte offset are ignored.
    assign req_idx     = req_addr[idx_bits+1:2];
    assign init_idx    = init_addr[idx_bits+1:2];
    assign unused_init = ^init_addr;

    assign resp_xfer = resp_val && resp_rdy;
    // A draining response frees a slot in the same cycle, so a full server still accepts then.
    assign req_rdy   = !rst && !init_en && ((occ < occ_bits'(p_resp_depth)) || resp_xfer);
    assign req_xfer  = req_val && req_rdy;
    assign is_write  = (req_op == mem_msg_write);

    // Reads see the array as of cycle start; writes respond with zero data.
    assign new_msg = {req_op, req_opaque, req_addr, req_len,
                      is_write ? {p_data_bits{1'b0}} : mem[req_idx]};

    // Array update: backdoor load, or a byte-masked write (len=0 means the full word).
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_idx] <= init_data;
        end else if (req_xfer && is_write) begin
            for (int b = 0; b < p_len_bits; b++) begin
                if ((req_len == '0) || (b < int'(req_len))) begin
                    mem[req_idx][8*b +: 8] <= req_data[8*b +: 8];
                end
            end
        end
    end

    // Occupancy covers everything in the delay pipeline plus the response buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= '0;
        end else if (req_xfer && !resp_xfer) begin
            occ <= occ + 1'b1;
        end else if (!req_xfer && resp_xfer) begin
            occ <= occ - 1'b1;
        end
    end

    // The buffer write itself is the last delay cycle, so only p_latency-1 register stages exist.
    if (p_latency > 1) begin : g_pipe
        logic [p_latency-2:0] pv;
        logic [msg_bits-1:0]  pm [p_latency-1];

        // Valid shift chain, cleared on reset so in-flight requests are discarded.
        always_ff @(posedge clk) begin
            if (rst) begin
                pv <= '0;
            end else begin
                pv[0] <= req_xfer;
                for (int i = 1; i < p_latency - 1; i++) begin
                    pv[i] <= pv[i-1];
                end
            end
        end

        // Message shift chain; contents only matter where the matching valid is set.
        always_ff @(posedge clk) begin
            pm[0] <= new_msg;
            for (int i = 1; i < p_latency - 1; i++) begin
                pm[i] <= pm[i-1];
            end
        end

        assign push_val = pv[p_latency-2];
        assign push_msg = pm[p_latency-2];
    end else begin : g_nopipe
        assign push_val = req_xfer;
        assign push_msg = new_msg;
    end

    function automatic logic [ptr_bits-1:0] ptr_next(input logic [ptr_bits-1:0] p);
        return (p == ptr_bits'(p_resp_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Response buffer pointers and count; occupancy bounds guarantee it never overflows.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push_val) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (resp_xfer) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_val && !resp_xfer) begin
                fcnt <= fcnt + 1'b1;
            end else if (!push_val && resp_xfer) begin
                fcnt <= fcnt - 1'b1;
            end
        end
    end

    // Response buffer storage; the head entry holds still while resp_rdy is low.
    always_ff @(posedge clk) begin
        if (push_val) begin
            fifo[wr_ptr] <= push_msg;
        end
    end

    assign resp_val = (fcnt != '0);
    assign {resp_op, resp_opaque, resp_addr, resp_len, resp_data} = fifo[rd_ptr];

endmodule

// File: tb/tb_inst_mem_server.sv
// tb/tb_inst_mem_server.sv - scoreboard and vector-table bench for inst_mem_server
module tb_inst_mem_server;
    localparam logic [2:0] op_rd = 3'd0;
    localparam logic [2:0] op_wr = 3'd1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic [2:0]  req_op;
    logic [7:0]  req_opaque;
    logic [31:0] req_addr;
    logic [3:0]  req_len;
    logic [31:0] req_data;
    logic        resp_val;
    logic        resp_rdy;
    logic [2:0]  resp_op;
    logic [7:0]  resp_opaque;
    logic [31:0] resp_addr;
    logic [3:0]  resp_len;
    logic [31:0] resp_data;
    logic        init_en;
    logic [31:0] init_addr;
    logic [31:0] init_data;

    inst_mem_server dut (
        .clk        (clk),
        .rst        (rst),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_op     (req_op),
        .req_opaque (req_opaque),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_data   (req_data),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_op    (resp_op),
        .resp_opaque(resp_opaque),
        .resp_addr  (resp_addr),
        .resp_len   (resp_len),
        .resp_data  (resp_data),
        .init_en    (init_en),
        .init_addr  (init_addr),
        .init_data  (init_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
        int          acc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
        logic [7:0]  opq;
        logic [31:0] exp_data;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          lat_mode = 1'b0;
    logic        held = 1'b0;
    logic [78:0] held_msg;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every transfer and checks hold-stability.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held) begin
                chk("resp_hold", 128'({resp_val, resp_op, resp_opaque, resp_addr, resp_len, resp_data}),
                    128'({1'b1, held_msg}));
            end
            if (resp_val && resp_rdy) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp: got opaque %0h addr %0h, expected no response",
                             resp_opaque, resp_addr);
                end else begin
                    mon_e = sb.pop_front();
                    chk("resp_msg", 128'({resp_op, resp_opaque, resp_addr, resp_len, resp_data}),
                        128'({mon_e.op, mon_e.opaque, mon_e.addr, mon_e.len, mon_e.data}));
                    if (mon_e.chk_lat) begin
                        chk("resp_latency", 128'(cyc - mon_e.acc), 128'(2));
                    end
                end
            end
            held     = resp_val && !resp_rdy;
            held_msg = {resp_op, resp_opaque, resp_addr, resp_len, resp_data};
        end
    end

    task automatic push_exp(input logic [2:0] op, input logic [7:0] opq, input logic [31:0] addr,
                            input logic [3:0] len, input logic [31:0] data);
        exp_t e;
        e.op = op; e.opaque = opq; e.addr = addr; e.len = len; e.data = data;
        e.acc = cyc; e.chk_lat = lat_mode;
        sb.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the request is accepted.
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] len,
                        input logic [31:0] data, input logic [7:0] opq, input logic [31:0] exp_data);
        int n = 0;
        req_val = 1'b1; req_op = op; req_addr = addr; req_len = len; req_data = data; req_opaque = opq;
        @(negedge clk);
        while (!req_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_rdy) begin
            failures++;
            $display("FAIL req_timeout: req_rdy 0 after %0d cycles, required 1", n);
        end else begin
            push_exp(op, opq, addr, len, exp_data);
        end
        @(posedge clk);
        #1;
        req_val = 1'b0;
    endtask

    task automatic init_write(input logic [31:0] addr, input logic [31:0] data);
        init_en = 1'b1; init_addr = addr; init_data = data;
        @(negedge clk);
        chk("init_blocks_req", 128'(req_rdy), 128'(0));
        @(posedge clk);
        #1;
        init_en = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'(0));
    endtask

    function automatic logic [31:0] stream_word(input int i);
        if (i == 0) return 32'h0000_0013;
        if (i == 1) return 32'h0050_0093;
        return 32'h1000_0000 + 32'(i);
    endfunction

    vec_t tbl[12];
    int   k;

    initial begin
        tbl[0]  = '{op_wr, 32'h40,       4'd0, 32'hDEAD_BEEF, 8'h10, 32'h0};
        tbl[1]  = '{op_wr, 32'h40,       4'd1, 32'h1234_56AA, 8'h11, 32'h0};
        tbl[2]  = '{op_rd, 32'h40,       4'd0, 32'h0,         8'h12, 32'hDEAD_BEAA};
        tbl[3]  = '{op_wr, 32'h44,       4'd0, 32'hFFFF_FFFF, 8'h13, 32'h0};
        tbl[4]  = '{op_wr, 32'h44,       4'd2, 32'hA5A5_1234, 8'h14, 32'h0};
        tbl[5]  = '{op_rd, 32'h44,       4'd0, 32'h0,         8'h15, 32'hFFFF_1234};
        tbl[6]  = '{op_wr, 32'h44,       4'd3, 32'h77AB_CDEF, 8'h16, 32'h0};
        tbl[7]  = '{op_rd, 32'h46,       4'd2, 32'h0,         8'h17, 32'hFFAB_CDEF};
        tbl[8]  = '{op_wr, 32'h0,        4'd0, 32'hCAFE_F00D, 8'h18, 32'h0};
        tbl[9]  = '{op_rd, 32'h400,      4'd0, 32'h0,         8'h19, 32'hCAFE_F00D};
        tbl[10] = '{op_rd, 32'h8000_0003, 4'd0, 32'h0,        8'h1A, 32'hCAFE_F00D};
        tbl[11] = '{op_rd, 32'h100,      4'd0, 32'h0,         8'h1B, 32'h0000_0013};

        rst = 1'b1; req_val = 1'b0; req_op = op_rd; req_opaque = '0; req_addr = '0;
        req_len = '0; req_data = '0; resp_rdy = 1'b1; init_en = 1'b0; init_addr = '0; init_data = '0;

        // Reset state
        @(negedge clk);
        chk("reset_req_rdy", 128'(req_rdy), 128'(0));
        chk("reset_resp_val", 128'(resp_val), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_rdy", 128'(req_rdy), 128'(1));
        @(posedge clk);
        #1;

        // Backdoor load of the program window 0x100..0x11C
        for (int i = 0; i < 8; i++) init_write(32'h100 + 32'(4 * i), stream_word(i));

        // Single read, exact latency
        lat_mode = 1'b1;
        send(op_rd, 32'h100, 4'd0, 32'h0, 8'h07, 32'h0000_0013);
        wait_drain();

        // Back-to-back stream: fixed latency on each implies one response per cycle
        for (int i = 0; i < 8; i++) send(op_rd, 32'h100 + 32'(4 * i), 4'd0, 32'h0, 8'(i), stream_word(i));
        wait_drain();
        lat_mode = 1'b0;

        // Vector table: byte-masked writes, aliasing, echo fields
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].op, tbl[i].addr, tbl[i].len, tbl[i].data, tbl[i].opq, tbl[i].exp_data);
        end
        wait_drain();

        // Backpressure: fill to capacity, then release in the same cycle
        resp_rdy = 1'b0; req_op = op_rd; req_addr = 32'h104; req_len = '0; req_data = '0;
        k = 0; req_opaque = 8'h20; req_val = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (req_rdy) begin
                push_exp(op_rd, req_opaque, 32'h104, 4'd0, 32'h0050_0093);
                k++;
            end
            @(posedge clk);
            #1;
            req_opaque = 8'h20 + 8'(k);
        end
        chk("bp_accept_count", 128'(k), 128'(4));
        @(negedge clk);
        chk("bp_full_rdy", 128'(req_rdy), 128'(0));
        @(posedge clk);
        #1;
        resp_rdy = 1'b1;
        @(negedge clk);
        chk("bp_rdy_same_cycle", 128'(req_rdy), 128'(1));
        if (req_rdy) push_exp(op_rd, req_opaque, 32'h104, 4'd0, 32'h0050_0093);
        @(posedge clk);
        #1;
        req_val = 1'b0;
        wait_drain();

        // Reset with three responses in flight
        resp_rdy = 1'b0;
        for (int i = 0; i < 3; i++) send(op_rd, 32'h100, 4'd0, 32'h0, 8'h30 + 8'(i), 32'h0000_0013);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("pre_reset_val", 128'(resp_val), 128'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_resp_val", 128'(resp_val), 128'(0));
        chk("rst_req_rdy", 128'(req_rdy), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_rdy = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("post_reset_empty", 128'(resp_val), 128'(0));
        @(posedge clk);
        #1;
        send(op_rd, 32'h40, 4'd0, 32'h0, 8'h40, 32'hDEAD_BEAA);
        send(op_rd, 32'h104, 4'd0, 32'h0, 8'h41, 32'h0050_0093);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
